// File: rtl/xnor_gate_3in.sv
// -----------------------------------------------------------------------------
// xnor_gate_3in
//
// Purpose:
//   Pipelined 3-input bitwise XNOR (even-parity) stage with a valid qualifier
//   and a saturating hit counter for debug/coverage.
//     r[i] = ~(din_a[i] ^ din_b[i] ^ din_c[i])   (1 when an even number of 1s)
//
// Build option:
//   XNOR3_BYPASS_EN  - when defined, dout/dout_valid are driven combinationally
//                      (zero latency) and forced to 0 while rst_n is low.
//                      hit_cnt stays registered in both builds.
//                      When undefined (default), dout/dout_valid are registered
//                      with one cycle of latency.
//
// Parameters:
//   WIDTH  - bit width of each operand and of dout (>= 1)
//   CNT_W  - width of the saturating hit counter (>= 2)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   din_valid  in   qualifies din_a/b/c this cycle
//   din_a/b/c  in   operands [WIDTH-1:0]
//   cnt_clr    in   synchronous clear of hit_cnt (wins over increment)
//   dout       out  bitwise XNOR result [WIDTH-1:0]
//   dout_valid out  dout holds a freshly computed result
//   hit_cnt    out  accepted samples with result bit 0 = 1, saturating
// -----------------------------------------------------------------------------
module xnor_gate_3in #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic [WIDTH-1:0] din_c,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] w_r;
  logic             w_hit;
  logic [CNT_W-1:0] r_hit_cnt;

  assign w_r = ~(din_a ^ din_b ^ din_c);

  // Qualify with din_valid first so X/Z data on idle cycles cannot reach
  // the counter enable.
  assign w_hit = din_valid & w_r[0];

  // Saturating hit counter; clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt <= '0;
    end else if (cnt_clr) begin
      r_hit_cnt <= '0;
    end else if (w_hit && (r_hit_cnt != CNT_MAX)) begin
      r_hit_cnt <= r_hit_cnt + CNT_ONE;
    end
  end

  assign hit_cnt = r_hit_cnt;

`ifdef XNOR3_BYPASS_EN
  // Zero-latency path. dout is also gated by din_valid so that X/Z on idle
  // data inputs never shows up on the output.
  assign dout       = (rst_n && din_valid) ? w_r : '0;
  assign dout_valid = rst_n & din_valid;
`else
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;

  // dout only loads on valid cycles and otherwise holds; dout_valid is a
  // one-cycle strobe that follows din_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      if (din_valid) begin
        r_dout <= w_r;
      end
      r_dout_valid <= din_valid;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
`endif

endmodule

// File: tb/tb_xnor_gate_3in.sv
module tb_xnor_gate_3in;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Wide instance: WIDTH=8, CNT_W=16
  logic       v8, clr8, dv8;
  logic [7:0] a8, b8, c8, d8;
  logic [15:0] cnt8;

  // Narrow instance: WIDTH=1, CNT_W=2 (saturation tests)
  logic       v1, clr1, dv1;
  logic       a1, b1, c1, d1;
  logic [1:0] cnt1;

  xnor_gate_3in #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .din_valid(v8),
    .din_a(a8), .din_b(b8), .din_c(c8), .cnt_clr(clr8),
    .dout(d8), .dout_valid(dv8), .hit_cnt(cnt8)
  );

  xnor_gate_3in #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .din_valid(v1),
    .din_a(a1), .din_b(b1), .din_c(c1), .cnt_clr(clr1),
    .dout(d1), .dout_valid(dv1), .hit_cnt(cnt1)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {logic [7:0] d; logic v; logic [15:0] c;} exp8_t;
  typedef struct packed {logic d; logic v; logic [1:0] c;} exp1_t;
  exp8_t q8[$];
  exp1_t q1[$];

  // Reference model state
  logic [7:0]  m_d8;
  logic [15:0] m_c8;
  logic        m_d1;
  logic [1:0]  m_c1;

  // Reference: bit is 1 when the count of ones across the three inputs is even.
  function automatic logic [7:0] ref_xnor(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      int n;
      n = 0;
      if (a[i] === 1'b1) n++;
      if (b[i] === 1'b1) n++;
      if (c[i] === 1'b1) n++;
      r[i] = ((n % 2) == 0);
    end
    return r;
  endfunction

  // One transaction on the wide instance: drive, push expectation, pop/compare.
  task automatic xfer8(input string name, input logic v, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c, input logic clr);
    exp8_t e;
    logic [7:0] r;
    a8 = a; b8 = b; c8 = c; v8 = v; clr8 = clr;
    r = ref_xnor(a, b, c);
`ifdef XNOR3_BYPASS_EN
    e.d = v ? r : 8'h00;
`else
    if (v) m_d8 = r;
    e.d = m_d8;
`endif
    e.v = v;
    if (clr) m_c8 = 16'd0;
    else if (v && r[0] && m_c8 != 16'hFFFF) m_c8 = m_c8 + 16'd1;
    e.c = m_c8;
    q8.push_back(e);
`ifdef XNOR3_BYPASS_EN
    #1;
`else
    @(posedge clk); #1;
`endif
    e = q8.pop_front();
    $display("[%0t] %s w8 a=%h b=%h c=%h v=%b clr=%b -> dout=%h vld=%b cnt=%0d",
             $time, name, a, b, c, v, clr, d8, dv8, cnt8);
    checks++;
    if (d8 !== e.d) begin
      failures++;
      $display("FAIL %s dout8 got=%h exp=%h", name, d8, e.d);
    end
    checks++;
    if (dv8 !== e.v) begin
      failures++;
      $display("FAIL %s dout_valid8 got=%b exp=%b", name, dv8, e.v);
    end
`ifdef XNOR3_BYPASS_EN
    @(posedge clk); #1;
`endif
    checks++;
    if (cnt8 !== e.c) begin
      failures++;
      $display("FAIL %s hit_cnt8 got=%0d exp=%0d", name, cnt8, e.c);
    end
  endtask

  task automatic xfer1(input string name, input logic v, input logic a,
                       input logic b, input logic c, input logic clr);
    exp1_t e;
    logic [7:0] r;
    a1 = a; b1 = b; c1 = c; v1 = v; clr1 = clr;
    r = ref_xnor({7'd0, a}, {7'd0, b}, {7'd0, c});
`ifdef XNOR3_BYPASS_EN
    e.d = v ? r[0] : 1'b0;
`else
    if (v) m_d1 = r[0];
    e.d = m_d1;
`endif
    e.v = v;
    if (clr) m_c1 = 2'd0;
    else if (v && r[0] && m_c1 != 2'd3) m_c1 = m_c1 + 2'd1;
    e.c = m_c1;
    q1.push_back(e);
`ifdef XNOR3_BYPASS_EN
    #1;
`else
    @(posedge clk); #1;
`endif
    e = q1.pop_front();
    $display("[%0t] %s w1 a=%b b=%b c=%b v=%b clr=%b -> dout=%b vld=%b cnt=%0d",
             $time, name, a, b, c, v, clr, d1, dv1, cnt1);
    checks++;
    if (d1 !== e.d) begin
      failures++;
      $display("FAIL %s dout1 got=%b exp=%b", name, d1, e.d);
    end
    checks++;
    if (dv1 !== e.v) begin
      failures++;
      $display("FAIL %s dout_valid1 got=%b exp=%b", name, dv1, e.v);
    end
`ifdef XNOR3_BYPASS_EN
    @(posedge clk); #1;
`endif
    checks++;
    if (cnt1 !== e.c) begin
      failures++;
      $display("FAIL %s hit_cnt1 got=%0d exp=%0d", name, cnt1, e.c);
    end
  endtask

  task automatic check_all_zero(input string name);
    $display("[%0t] %s dout8=%h vld8=%b cnt8=%0d dout1=%b vld1=%b cnt1=%0d",
             $time, name, d8, dv8, cnt8, d1, dv1, cnt1);
    checks++;
    if ({d8, dv8, cnt8} !== 25'd0) begin
      failures++;
      $display("FAIL %s w8 got dout=%h vld=%b cnt=%0d exp all 0", name, d8, dv8, cnt8);
    end
    checks++;
    if ({d1, dv1, cnt1} !== 4'd0) begin
      failures++;
      $display("FAIL %s w1 got dout=%b vld=%b cnt=%0d exp all 0", name, d1, dv1, cnt1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v8 = 0; clr8 = 0; a8 = 0; b8 = 0; c8 = 0;
    v1 = 0; clr1 = 0; a1 = 0; b1 = 0; c1 = 0;
    #22;  // spans clock edges while held in reset
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_d8 = 8'd0; m_c8 = 16'd0; m_d1 = 1'b0; m_c1 = 2'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_truth_table();
    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      xfer8("truth", 1'b1, {8{abc[2]}}, {8{abc[1]}}, {8{abc[0]}}, 1'b0);
    end
    checks++;
    if (cnt8 !== 16'd4) begin
      failures++;
      $display("FAIL truth_end hit_cnt8 got=%0d exp=4", cnt8);
    end
  endtask

  task automatic test_hold();
    xfer8("hold", 1'b1, 8'h00, 8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      xfer8("hold_idle", 1'b0, 8'hxx, 8'hzz, 8'hFF, 1'b0);
    end
  endtask

  task automatic test_reset_midstream();
    xfer8("mid_clr", 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) xfer8("mid_fill", 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;  // no clock edge has occurred since rst_n fell
    check_all_zero("reset_async");
    @(posedge clk); #1;
    check_all_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    v8 = 1'b0; clr8 = 1'b0;
    m_d8 = 8'd0; m_c8 = 16'd0; m_d1 = 1'b0; m_c1 = 2'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_counter();
    for (int i = 0; i < 5; i++) xfer1("cnt_sat", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    xfer1("cnt_clr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    xfer1("cnt_miss", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    v1 = 1'b0;
  endtask

  task automatic test_bitwise();
    xfer8("bitwise", 1'b1, 8'hF0, 8'hCC, 8'hAA, 1'b0);
    checks++;
    if (d8 !== 8'h69) begin
      failures++;
      $display("FAIL bitwise_const dout8 got=%h exp=69", d8);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      xfer8("b2b", ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
            8'($urandom), ($urandom_range(0, 7) == 0));
    end
    v8 = 1'b0; clr8 = 1'b0;
  endtask

`ifdef XNOR3_BYPASS_EN
  task automatic test_bypass();
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1; v1 = 1'b1; clr1 = 1'b0;
    @(negedge clk); #1;  // well away from any rising edge
    $display("[%0t] bypass w1 a=1 b=0 c=1 v=1 -> dout=%b vld=%b", $time, d1, dv1);
    checks++;
    if ({d1, dv1} !== 2'b11) begin
      failures++;
      $display("FAIL bypass dout/vld got=%b%b exp=11", d1, dv1);
    end
    @(posedge clk); #1;
    v1 = 1'b0;
    if (m_c1 != 2'd3) m_c1 = m_c1 + 2'd1;
  endtask
`endif

  initial begin
    fork
      begin
        #50000;
        $display("FAIL timeout sim did not finish in time");
        $fatal(1, "timeout");
      end
    join_none
    test_reset();
    test_truth_table();
    test_hold();
    test_reset_midstream();
    test_counter();
    test_bitwise();
    test_back_to_back();
`ifdef XNOR3_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
